branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Dynamic branch predictor and mispredict controller for the pipelined core.
- IF stage: looks up a 2-bit saturating BHT and a direct-mapped BTB by fetch PC, and supplies predicted direction and target.
- EX stage: consumes the resolved outcome from the branch comparator, trains the tables, and raises flush/redirect on mispredict.
- Keeps branch and mispredict performance counters.

Parameters:
INDEX_BITS, 6, log2 of table entries (64 entries); index = pc[INDEX_BITS+1:2]
XLEN, 32, address width
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_pc  in  XLEN  fetch-stage PC
predict_taken  out  1  predicted taken for if_pc
predict_target  out  XLEN  BTB target for if_pc (valid when predict_taken=1)
ex_valid  in  1  EX stage holds a live instruction (not bubble/stalled)
ex_branch  in  1  EX instruction is a conditional branch (Branch)
ex_pc  in  XLEN  PC of EX instruction
ex_taken  in  1  resolved outcome (branch_taken)
ex_target  in  XLEN  resolved branch target (pc+imm)
ex_pred_taken  in  1  prediction carried down pipeline with this instruction
ex_pred_target  in  XLEN  predicted target carried down pipeline
flush  out  1  mispredict: squash IF/ID and ID/EX this cycle
redirect_pc  out  XLEN  correct next PC when flush=1
branch_count  out  CNT_W  resolved branches since reset
mispredict_count  out  CNT_W  mispredicts since reset

Behaviour:
- Reset: all BHT counters = WNT (2'b01); all BTB valid = 0; both perf counters = 0. flush is forced to 0 while rst=1. rst has priority over any update in the same cycle.
- Lookup is combinational from registered state: predict_taken = bht[idx][1] & btb_valid[idx] & (btb_tag[idx] == if_pc[XLEN-1:INDEX_BITS+2]); predict_target = btb_target[idx]. Zero-cycle latency.
- Resolve is qualified by res = ex_valid & ex_branch.
- mispredict = res & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
- flush = mispredict, combinational in the same cycle. redirect_pc = ex_taken ? ex_target : ex_pc + 4, driven whenever res=1 and otherwise don't-care (hold 0).
- Update happens on the clock edge when res=1:
  - BHT counter increments if ex_taken and decrements otherwise, saturating at SNT(00) and ST(11).
  - If ex_taken: btb_valid=1, tag and target are written from ex_pc/ex_target.
  - Not-taken branches leave the BTB untouched.
- Performance counters:
  - branch_count += 1 on res.
  - mispredict_count += 1 on mispredict.
  - Both saturate at all-ones and never wrap.
- Same-index lookup and update in one cycle: lookup returns the pre-update value, with no bypass. Update is visible from the next cycle.
- Aliasing: a tag mismatch yields predict_taken=0 regardless of the counter. The counter is shared across aliases, and this is intended.
- ex_valid=0 or ex_branch=0: no state change and flush=0.
- The BTB and BHT are not cleared by flush. Only rst clears them.

Decomposition:
- Package bp_pkg:
  - typedef enum logic[1:0] bht_state_t {SNT, WNT, WT, ST}
  - localparam BHT_RESET = WNT
  - helper localparams for index/tag slice widths derived from INDEX_BITS and XLEN
- Sub-module bp_sat_counter: a 2-bit saturating up/down counter (inc/dec enable, sync reset to WNT), instantiated per BHT entry via generate.
- BTB arrays are inline.

Test Plan:
- Reset, then if_pc=0x100 → predict_taken=0, branch_count=0, mispredict_count=0, flush=0.
- Resolve taken branch ex_pc=0x100, ex_target=0x80, ex_pred_taken=0 → flush=1 and redirect_pc=0x80 that cycle. Next cycle if_pc=0x100 → predict_taken=1 (WNT→WT), predict_target=0x80, mispredict_count=1.
- Three more taken resolves at 0x100 reach ST; one not-taken (pred=1) gives flush=1, redirect_pc=0x104, state WT, predict_taken still 1. A second not-taken gives WNT and predict_taken=0.
- Alias: train 0x100 taken, then lookup if_pc=0x200 (same index, 64 entries) → predict_taken=0 from tag mismatch.
- Target mismatch: ex_taken=1, ex_pred_taken=1, ex_pred_target=0x80, ex_target=0x90 → flush=1, redirect_pc=0x90, BTB target becomes 0x90.
- ex_valid=0 with ex_branch=1, ex_taken=1 → flush=0 and no counter or table change. Assert rst in the same cycle as a mispredicting resolve → flush=0 and all state returns to reset values next cycle.

Source files
------------

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and helpers for the branch predictor unit
//               (BHT counter encoding, reset state, table slice widths).
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // 2-bit saturating direction counter encoding
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam bht_state_t BHT_RESET = WNT;

  // Default geometry; tables are indexed by pc[INDEX_BITS+1:2]
  localparam int DEF_INDEX_BITS = 6;
  localparam int DEF_XLEN       = 32;

  // Number of PC bits above the index, used as the BTB tag
  function automatic int tag_width(input int xlen, input int index_bits);
    return xlen - index_bits - 2;
  endfunction

  // Number of table entries for a given index width
  function automatic int table_entries(input int index_bits);
    return 1 << index_bits;
  endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : bp_sat_counter
// Description : One BHT entry - 2-bit saturating up/down direction counter
//               with synchronous reset to weakly-not-taken.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output bht_state_t state
);

  bht_state_t r_state;
  bht_state_t w_next;

  // Next-state: step toward ST on inc, toward SNT on dec, hold at the ends
  always_comb begin
    w_next = r_state;
    case (r_state)
      SNT:     if (inc) w_next = WNT;
      WNT:     if (inc) w_next = WT;  else if (dec) w_next = SNT;
      WT:      if (inc) w_next = ST;  else if (dec) w_next = WNT;
      ST:      if (dec) w_next = WT;
      default: w_next = BHT_RESET;
    endcase
  end

  // State register; reset wins over any same-cycle training
  always_ff @(posedge clk) begin
    if (rst) r_state <= BHT_RESET;
    else     r_state <= w_next;
  end

  assign state = r_state;

endmodule : bp_sat_counter
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : IF-stage BHT/BTB lookup, EX-stage training, mispredict
//               flush/redirect and branch/mispredict performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int XLEN       = DEF_XLEN,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             predict_taken,
  output logic [XLEN-1:0]  predict_target,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int ENTRIES = table_entries(INDEX_BITS);
  localparam int TAG_W   = tag_width(XLEN, INDEX_BITS);

  // Table storage
  bht_state_t       w_bht        [ENTRIES];
  logic             r_btb_valid  [ENTRIES];
  logic [TAG_W-1:0] r_btb_tag    [ENTRIES];
  logic [XLEN-1:0]  r_btb_target [ENTRIES];

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [TAG_W-1:0]      w_if_tag;
  logic [INDEX_BITS-1:0] w_ex_idx;
  logic [TAG_W-1:0]      w_ex_tag;
  logic [1:0]            w_if_ctr;
  logic                  w_res;
  logic                  w_mispredict;
  logic                  w_unused_if_pc;

  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  assign w_if_idx       = if_pc[INDEX_BITS+1:2];
  assign w_if_tag       = if_pc[XLEN-1:INDEX_BITS+2];
  assign w_ex_idx       = ex_pc[INDEX_BITS+1:2];
  assign w_ex_tag       = ex_pc[XLEN-1:INDEX_BITS+2];
  assign w_unused_if_pc = |if_pc[1:0];

  // Lookup reads registered state only, so a same-cycle update is not seen
  assign w_if_ctr       = w_bht[w_if_idx];
  assign predict_taken  = w_if_ctr[1] & r_btb_valid[w_if_idx] &
                          (r_btb_tag[w_if_idx] == w_if_tag);
  assign predict_target = r_btb_target[w_if_idx];

  // Resolve qualification and mispredict detection (direction or target)
  assign w_res        = ex_valid & ex_branch;
  assign w_mispredict = w_res & ((ex_taken != ex_pred_taken) |
                        (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
  assign flush        = w_mispredict & ~rst;
  assign redirect_pc  = !w_res   ? '0 :
                        ex_taken ? ex_target : ex_pc + XLEN'(4);

  // One saturating counter per BHT entry, trained only at the resolving index
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_bht
    logic w_hit;
    assign w_hit = w_res & (w_ex_idx == INDEX_BITS'(gi));
    bp_sat_counter u_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_hit & ex_taken),
      .dec   (w_hit & ~ex_taken),
      .state (w_bht[gi])
    );
  end

  // BTB valid bits: cleared only by reset, set when a taken branch resolves
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_btb_valid[i] <= 1'b0;
    end else if (w_res && ex_taken) begin
      r_btb_valid[w_ex_idx] <= 1'b1;
    end
  end

  // BTB tag/target payload; meaningless until the matching valid bit is set
  always_ff @(posedge clk) begin
    if (!rst && w_res && ex_taken) begin
      r_btb_tag[w_ex_idx]    <= w_ex_tag;
      r_btb_target[w_ex_idx] <= ex_target;
    end
  end

  // Performance counters saturate at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_res && (r_branch_count != '1))
        r_branch_count <= r_branch_count + CNT_W'(1);
      if (w_mispredict && (r_mispredict_count != '1))
        r_mispredict_count <= r_mispredict_count + CNT_W'(1);
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule : branch_predict_unit
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Directed self-checking bench for branch_predict_unit.
//               Counters use a 4-bit width so saturation is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [XLEN-1:0]  if_pc;
  logic             predict_taken;
  logic [XLEN-1:0]  predict_target;
  logic             ex_valid;
  logic             ex_branch;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_taken;
  logic [XLEN-1:0]  ex_target;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic             flush;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  int passed = 0;
  int total  = 0;

  branch_predict_unit #(.INDEX_BITS(6), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .ex_valid         (ex_valid),
    .ex_branch        (ex_branch),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change at negedge; checks happen 1 time unit later
  task automatic drive(input logic v, input logic b, input logic [31:0] pc,
                       input logic t, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    ex_valid = v; ex_branch = b; ex_pc = pc; ex_taken = t;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0; ex_branch = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h100;
    ex_valid = 0; ex_branch = 0; ex_pc = 0; ex_taken = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;

    // Reset state
    check("reset_pred",   predict_taken, 0);
    check("reset_bcnt",   branch_count, 0);
    check("reset_mcnt",   mispredict_count, 0);
    check("reset_flush",  flush, 0);

    // First taken resolve mispredicts; lookup still sees pre-update state
    drive(1, 1, 32'h100, 1, 32'h80, 0, 32'h0);
    check("t1_flush",     flush, 1);
    check("t1_redirect",  redirect_pc, 32'h80);
    check("t1_nobypass",  predict_taken, 0);
    next_cycle();
    check("t1_pred",      predict_taken, 1);
    check("t1_target",    predict_target, 32'h80);
    check("t1_mcnt",      mispredict_count, 1);
    check("t1_bcnt",      branch_count, 1);

    // Three correctly-predicted taken resolves: WT -> ST (saturated)
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h100, 1, 32'h80, 1, 32'h80);
      check("t3_noflush", flush, 0);
      next_cycle();
    end
    check("t3_bcnt",      branch_count, 4);
    check("t3_mcnt",      mispredict_count, 1);

    // Not-taken while predicted taken: ST -> WT, still predicts taken
    drive(1, 1, 32'h100, 0, 32'h80, 1, 32'h80);
    check("nt1_flush",    flush, 1);
    check("nt1_redirect", redirect_pc, 32'h104);
    next_cycle();
    check("nt1_pred",     predict_taken, 1);
    // Second not-taken: WT -> WNT, no longer predicts taken
    drive(1, 1, 32'h100, 0, 32'h80, 1, 32'h80);
    check("nt2_flush",    flush, 1);
    next_cycle();
    check("nt2_pred",     predict_taken, 0);
    check("nt2_mcnt",     mispredict_count, 3);
    check("nt2_bcnt",     branch_count, 6);

    // Alias: 0x200 shares index 0 with 0x100 but has a different tag
    drive(1, 1, 32'h100, 1, 32'h80, 0, 32'h0);
    next_cycle();
    check("alias_own",    predict_taken, 1);
    if_pc = 32'h200; #1;
    check("alias_other",  predict_taken, 0);
    if_pc = 32'h100; #1;

    // Target mismatch with correct direction
    drive(1, 1, 32'h100, 1, 32'h90, 1, 32'h80);
    check("tm_flush",     flush, 1);
    check("tm_redirect",  redirect_pc, 32'h90);
    next_cycle();
    check("tm_target",    predict_target, 32'h90);
    check("tm_mcnt",      mispredict_count, 5);
    check("tm_bcnt",      branch_count, 8);

    // Unqualified resolves change nothing (two would drop ST to WNT)
    drive(0, 1, 32'h100, 0, 32'h0, 1, 32'h90);
    check("inv_flush",    flush, 0);
    check("inv_redirect", redirect_pc, 0);
    next_cycle();
    drive(1, 0, 32'h100, 0, 32'h0, 1, 32'h90);
    check("nobr_flush",   flush, 0);
    next_cycle();
    check("inv_pred",     predict_taken, 1);
    check("inv_bcnt",     branch_count, 8);
    check("inv_mcnt",     mispredict_count, 5);

    // Reset concurrent with a mispredicting resolve
    rst = 1'b1;
    drive(1, 1, 32'h140, 1, 32'h40, 0, 32'h0);
    check("rst_flush",    flush, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; ex_valid = 0; ex_branch = 0; #1;
    check("rst_bcnt",     branch_count, 0);
    check("rst_mcnt",     mispredict_count, 0);
    check("rst_pred100",  predict_taken, 0);
    if_pc = 32'h140; #1;
    check("rst_pred140",  predict_taken, 0);

    // Counter saturation: 17 correct not-taken resolves, then 17 mispredicts
    if_pc = 32'h300;
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 32'h300, 0, 32'h0, 0, 32'h0);
      next_cycle();
    end
    check("sat_bcnt",     branch_count, 15);
    check("sat_mcnt0",    mispredict_count, 0);
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 32'h300, 0, 32'h0, 1, 32'h0);
      next_cycle();
    end
    check("sat_mcnt",     mispredict_count, 15);
    check("sat_bcnt2",    branch_count, 15);

    // BHT bottom saturation: SNT + one taken = WNT, not taken-predicting
    drive(1, 1, 32'h300, 1, 32'h10, 0, 32'h0);
    next_cycle();
    check("snt_pred",     predict_taken, 0);
    drive(1, 1, 32'h300, 1, 32'h10, 0, 32'h0);
    next_cycle();
    check("snt_pred2",    predict_taken, 1);
    check("snt_target",   predict_target, 32'h10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_branch_predict_unit
`default_nettype wire
